// File: rtl/calc_seq_pkg.sv
// Shared types and constants for the calc load-and-run sequencer.
package calc_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    RAMP,
    CONST,
    TRIG,
    WAIT,
    DONE,
    ERR
  } seq_state_e;

  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned WORD_SHIFT = $clog2(WORD_BYTES);

endpackage

// File: rtl/calc_seq_ramp_gen.sv
// Ramp value generator: captures base/step on load, then steps a running
// accumulator (modulo 2^DATA_W) and a word index on each advance.
module calc_seq_ramp_gen
  import calc_seq_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LEN_W  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_load,
  input  logic              i_advance,
  input  logic [DATA_W-1:0] i_base,
  input  logic [DATA_W-1:0] i_step,
  output logic [DATA_W-1:0] o_value,
  output logic [LEN_W-1:0]  o_index
);

  logic [DATA_W-1:0] r_step;
  logic [DATA_W-1:0] r_value;
  logic [LEN_W-1:0]  r_index;

  // Capture base/step on load; accumulate one step per advance.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_step  <= '0;
      r_value <= '0;
      r_index <= '0;
    end else if (i_load) begin
      r_step  <= i_step;
      r_value <= i_base;
      r_index <= '0;
    end else if (i_advance) begin
      r_value <= r_value + r_step;
      r_index <= r_index + LEN_W'(1);
    end
  end

  assign o_value = r_value;
  assign o_index = r_index;

endmodule

// File: rtl/calc_sequencer.sv
// Load-and-run controller for calc: after a settle delay it writes a linear
// ramp followed by NUM_CONST constants, pulses trigger, then waits for done
// with an optional timeout. All outputs are registered.
module calc_sequencer
  import calc_seq_pkg::*;
#(
  parameter int unsigned DATA_W        = 32,
  parameter int unsigned ADDR_W        = 32,
  parameter int unsigned LEN_W         = 16,
  parameter int unsigned NUM_CONST     = 3,
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter int unsigned TMO_W         = 24
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        start,
  input  logic [LEN_W-1:0]            ramp_len,
  input  logic [DATA_W-1:0]           ramp_base,
  input  logic [DATA_W-1:0]           ramp_step,
  input  logic [NUM_CONST*DATA_W-1:0] const_vals,
  input  logic [TMO_W-1:0]            timeout_cycles,
  output logic                        write,
  output logic [ADDR_W-1:0]           address,
  output logic [DATA_W-1:0]           din,
  output logic                        trigger,
  input  logic                        done,
  output logic                        busy,
  output logic                        finished,
  output logic                        timeout_err,
  output logic [LEN_W:0]              words_written
);

  localparam int unsigned SC_W   = (SETTLE_CYCLES < 1) ? 1 : $clog2(SETTLE_CYCLES + 1);
  localparam int unsigned CIDX_W = (NUM_CONST < 2) ? 1 : $clog2(NUM_CONST);
  localparam int unsigned WW_W   = LEN_W + 1;

  seq_state_e r_state, w_state_nxt;

  // Captured configuration
  logic [LEN_W-1:0]  r_len;
  logic [TMO_W-1:0]  r_tmo;
  logic [DATA_W-1:0] r_const [NUM_CONST];

  // Counters
  logic [SC_W-1:0]   r_settle, w_settle_nxt;
  logic [TMO_W-1:0]  r_tmo_cnt, w_tmo_nxt;
  logic [CIDX_W-1:0] r_cidx, w_cidx_nxt;

  // Registered outputs
  logic              r_write, w_write_nxt;
  logic [ADDR_W-1:0] r_address, w_addr_nxt;
  logic [DATA_W-1:0] r_din, w_din_nxt;
  logic              r_trigger, w_trig_nxt;
  logic              r_busy, w_busy_nxt;
  logic              r_finished, w_fin_nxt;
  logic              r_err, w_err_nxt;
  logic [WW_W-1:0]   r_ww, w_ww_nxt;

  // Ramp generator handshake and emit selection
  logic              w_load, w_adv;
  logic [DATA_W-1:0] w_val;
  logic [LEN_W-1:0]  w_idx;
  logic              w_emit_ramp, w_emit_const;
  logic [CIDX_W-1:0] w_emit_j;

  calc_seq_ramp_gen #(
    .DATA_W (DATA_W),
    .LEN_W  (LEN_W)
  ) u_ramp (
    .clock     (clock),
    .reset     (reset),
    .i_load    (w_load),
    .i_advance (w_adv),
    .i_base    (ramp_base),
    .i_step    (ramp_step),
    .o_value   (w_val),
    .o_index   (w_idx)
  );

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next state and next registered outputs. The state decides which word to
  // emit; the emit logic below is shared so ramp and constant writes stay
  // back-to-back across the RAMP->CONST boundary.
  always_comb begin
    w_state_nxt  = r_state;
    w_settle_nxt = r_settle;
    w_tmo_nxt    = r_tmo_cnt;
    w_cidx_nxt   = r_cidx;
    w_write_nxt  = 1'b0;
    w_addr_nxt   = '0;
    w_din_nxt    = '0;
    w_trig_nxt   = 1'b0;
    w_busy_nxt   = r_busy;
    w_fin_nxt    = 1'b0;
    w_err_nxt    = r_err;
    w_ww_nxt     = r_ww;
    w_load       = 1'b0;
    w_adv        = 1'b0;
    w_emit_ramp  = 1'b0;
    w_emit_const = 1'b0;
    w_emit_j     = '0;

    case (r_state)
      IDLE: begin
        if (start) begin
          w_load       = 1'b1;
          w_state_nxt  = SETTLE;
          w_busy_nxt   = 1'b1;
          w_err_nxt    = 1'b0;
          w_ww_nxt     = '0;
          w_settle_nxt = '0;
        end
      end
      SETTLE: begin
        if (r_settle == SC_W'(SETTLE_CYCLES)) begin
          if (r_len == '0) w_emit_const = 1'b1;
          else             w_emit_ramp  = 1'b1;
        end else begin
          w_settle_nxt = r_settle + SC_W'(1);
        end
      end
      RAMP: begin
        if (w_idx == r_len) w_emit_const = 1'b1;
        else                w_emit_ramp  = 1'b1;
      end
      CONST: begin
        if (r_cidx == CIDX_W'(NUM_CONST - 1)) begin
          w_state_nxt = TRIG;
          w_trig_nxt  = 1'b1;
        end else begin
          w_emit_const = 1'b1;
          w_emit_j     = r_cidx + CIDX_W'(1);
        end
      end
      TRIG: begin
        w_state_nxt = WAIT;
        w_tmo_nxt   = '0;
      end
      WAIT: begin
        if (done) begin
          w_state_nxt = DONE;
          w_fin_nxt   = 1'b1;
        end else if (r_tmo != '0 && r_tmo_cnt == r_tmo) begin
          w_state_nxt = ERR;
          w_err_nxt   = 1'b1;
        end else begin
          w_tmo_nxt = r_tmo_cnt + TMO_W'(1);
        end
      end
      DONE, ERR: begin
        w_state_nxt = IDLE;
        w_busy_nxt  = 1'b0;
      end
      default: w_state_nxt = IDLE;
    endcase

    if (w_emit_ramp) begin
      w_state_nxt = RAMP;
      w_write_nxt = 1'b1;
      w_addr_nxt  = ADDR_W'(w_idx) << WORD_SHIFT;
      w_din_nxt   = w_val;
      w_adv       = 1'b1;
      w_ww_nxt    = r_ww + WW_W'(1);
    end
    if (w_emit_const) begin
      w_state_nxt = CONST;
      w_write_nxt = 1'b1;
      w_addr_nxt  = (ADDR_W'(r_len) + ADDR_W'(w_emit_j)) << WORD_SHIFT;
      w_din_nxt   = r_const[w_emit_j];
      w_cidx_nxt  = w_emit_j;
      w_ww_nxt    = r_ww + WW_W'(1);
    end
  end

  // Config capture, counters and output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_len      <= '0;
      r_tmo      <= '0;
      for (int unsigned j = 0; j < NUM_CONST; j++) r_const[j] <= '0;
      r_settle   <= '0;
      r_tmo_cnt  <= '0;
      r_cidx     <= '0;
      r_write    <= 1'b0;
      r_address  <= '0;
      r_din      <= '0;
      r_trigger  <= 1'b0;
      r_busy     <= 1'b0;
      r_finished <= 1'b0;
      r_err      <= 1'b0;
      r_ww       <= '0;
    end else begin
      if (w_load) begin
        r_len <= ramp_len;
        r_tmo <= timeout_cycles;
        for (int unsigned j = 0; j < NUM_CONST; j++)
          r_const[j] <= const_vals[j*DATA_W +: DATA_W];
      end
      r_settle   <= w_settle_nxt;
      r_tmo_cnt  <= w_tmo_nxt;
      r_cidx     <= w_cidx_nxt;
      r_write    <= w_write_nxt;
      r_address  <= w_addr_nxt;
      r_din      <= w_din_nxt;
      r_trigger  <= w_trig_nxt;
      r_busy     <= w_busy_nxt;
      r_finished <= w_fin_nxt;
      r_err      <= w_err_nxt;
      r_ww       <= w_ww_nxt;
    end
  end

  assign write         = r_write;
  assign address       = r_address;
  assign din           = r_din;
  assign trigger       = r_trigger;
  assign busy          = r_busy;
  assign finished      = r_finished;
  assign timeout_err   = r_err;
  assign words_written = r_ww;

endmodule

// File: tb/tb_calc_sequencer.sv
// Scoreboard bench for calc_sequencer: each run pushes its expected writes,
// trigger, finished and timeout events (with their cycle numbers); a monitor
// pops and compares whenever the DUT presents one of them.
module tb_calc_sequencer;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int LEN_W  = 16;
  localparam int NC     = 3;
  localparam int S      = 16;
  localparam int TMO_W  = 24;

  logic                   clock = 1'b0;
  logic                   reset;
  logic                   start;
  logic [LEN_W-1:0]       ramp_len;
  logic [DATA_W-1:0]      ramp_base;
  logic [DATA_W-1:0]      ramp_step;
  logic [NC*DATA_W-1:0]   const_vals;
  logic [TMO_W-1:0]       timeout_cycles;
  logic                   write;
  logic [ADDR_W-1:0]      address;
  logic [DATA_W-1:0]      din;
  logic                   trigger;
  logic                   done;
  logic                   busy;
  logic                   finished;
  logic                   timeout_err;
  logic [LEN_W:0]         words_written;

  calc_sequencer #(
    .DATA_W        (DATA_W),
    .ADDR_W        (ADDR_W),
    .LEN_W         (LEN_W),
    .NUM_CONST     (NC),
    .SETTLE_CYCLES (S),
    .TMO_W         (TMO_W)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .start          (start),
    .ramp_len       (ramp_len),
    .ramp_base      (ramp_base),
    .ramp_step      (ramp_step),
    .const_vals     (const_vals),
    .timeout_cycles (timeout_cycles),
    .write          (write),
    .address        (address),
    .din            (din),
    .trigger        (trigger),
    .done           (done),
    .busy           (busy),
    .finished       (finished),
    .timeout_err    (timeout_err),
    .words_written  (words_written)
  );

  always #5 clock = ~clock;

  // Edge counter: at a negedge, cyc is the index of the most recent posedge.
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int                cyc;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  wr_t exp_wr_q[$];
  int  exp_trig_q[$];
  int  exp_fin_q[$];
  int  exp_err_q[$];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string nm);
    n_tests++;
    n_fail++;
    $display("FAIL %s: unexpected event at cycle %0d", nm, cyc);
  endtask

  // Monitor: compare every presented event against the scoreboard.
  bit prev_err = 1'b0;
  always @(negedge clock) begin
    if (!reset) begin
      if (write) begin
        if (exp_wr_q.size() == 0) unexpected("write");
        else begin
          wr_t w;
          w = exp_wr_q.pop_front();
          chk("write_cycle", 64'(cyc), 64'(w.cyc));
          chk("write_addr", 64'(address), 64'(w.addr));
          chk("write_din", 64'(din), 64'(w.data));
        end
      end
      if (trigger) begin
        if (exp_trig_q.size() == 0) unexpected("trigger");
        else chk("trigger_cycle", 64'(cyc), 64'(exp_trig_q.pop_front()));
      end
      if (finished) begin
        if (exp_fin_q.size() == 0) unexpected("finished");
        else chk("finished_cycle", 64'(cyc), 64'(exp_fin_q.pop_front()));
      end
      if (timeout_err && !prev_err) begin
        if (exp_err_q.size() == 0) unexpected("timeout_err");
        else chk("timeout_cycle", 64'(cyc), 64'(exp_err_q.pop_front()));
      end
    end
    prev_err = timeout_err;
  end

  // Reference: word k of the ramp is base + k*step; constants follow.
  task automatic expect_writes(input int e0, input int len, input logic [DATA_W-1:0] base,
                               input logic [DATA_W-1:0] step, input logic [NC*DATA_W-1:0] cv);
    logic [DATA_W-1:0] v;
    for (int k = 0; k < len; k++) begin
      v = base + step * DATA_W'(k);
      exp_wr_q.push_back('{e0 + S + 1 + k, ADDR_W'(k * 4), v});
    end
    for (int j = 0; j < NC; j++)
      exp_wr_q.push_back('{e0 + S + 1 + len + j, ADDR_W'((len + j) * 4), cv[j*DATA_W +: DATA_W]});
  endtask

  task automatic issue_start(input int len, input logic [DATA_W-1:0] base, input logic [DATA_W-1:0] step,
                             input logic [NC*DATA_W-1:0] cv, input int tmo, output int e0);
    @(negedge clock);
    ramp_len       = LEN_W'(len);
    ramp_base      = base;
    ramp_step      = step;
    const_vals     = cv;
    timeout_cycles = TMO_W'(tmo);
    start          = 1'b1;
    @(negedge clock);
    start = 1'b0;
    e0    = cyc;
    chk("busy_after_start", 64'(busy), 64'(1));
    chk("err_cleared_on_start", 64'(timeout_err), 64'(0));
    // Captured config must not follow later input changes.
    ramp_len       = LEN_W'($urandom);
    ramp_base      = $urandom;
    ramp_step      = $urandom;
    const_vals     = {$urandom, $urandom, $urandom};
    timeout_cycles = TMO_W'($urandom);
  endtask

  // One full run. d<0: done never asserted. d>=2: done pulsed d cycles after trigger.
  task automatic run(input int len, input logic [DATA_W-1:0] base, input logic [DATA_W-1:0] step,
                     input logic [NC*DATA_W-1:0] cv, input int tmo, input int d, input bit poke);
    int e0, trig, endc, guard;
    bit exp_fin;
    issue_start(len, base, step, cv, tmo, e0);
    expect_writes(e0, len, base, step, cv);
    trig = e0 + S + len + NC + 1;
    exp_trig_q.push_back(trig);
    exp_fin = (d >= 2) && (tmo == 0 || d <= tmo + 2);
    if (exp_fin) begin
      exp_fin_q.push_back(trig + d);
      endc = trig + d + 1;
    end else begin
      exp_err_q.push_back(trig + 2 + tmo);
      endc = trig + 3 + tmo;
    end
    if (poke) begin
      while (cyc < e0 + S + 1 + len / 2) @(negedge clock);
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
    end
    while (cyc < trig) @(negedge clock);
    if (d >= 2) begin
      repeat (d - 1) @(posedge clock);
      @(negedge clock);
      done = 1'b1;
      @(negedge clock);
      done = 1'b0;
    end
    guard = 0;
    while (busy && guard < 300) begin
      @(negedge clock);
      guard++;
    end
    chk("busy_released", 64'(busy), 64'(0));
    chk("busy_fall_cycle", 64'(cyc), 64'(endc));
    chk("words_written", 64'(words_written), 64'(len + NC));
    chk("timeout_err_final", 64'(timeout_err), 64'(!exp_fin));
    chk("pending_events", 64'(exp_wr_q.size() + exp_trig_q.size() + exp_fin_q.size() + exp_err_q.size()), 64'(0));
    if (!exp_fin) begin
      // Late done in IDLE must not produce a finished pulse.
      done = 1'b1;
      @(negedge clock);
      done = 1'b0;
      repeat (4) @(negedge clock);
      chk("err_sticky", 64'(timeout_err), 64'(1));
    end
  endtask

  task automatic check_all_zero(input string nm);
    chk({nm, "_outs"}, {write, trigger, busy, finished, timeout_err}, 64'(0));
    chk({nm, "_address"}, 64'(address), 64'(0));
    chk({nm, "_din"}, 64'(din), 64'(0));
    chk({nm, "_words"}, 64'(words_written), 64'(0));
  endtask

  initial begin
    int e0, len, tmo, d;
    reset = 1'b1; start = 1'b0; done = 1'b0;
    ramp_len = '0; ramp_base = '0; ramp_step = '0; const_vals = '0; timeout_cycles = '0;
    repeat (3) @(negedge clock);
    check_all_zero("reset");
    reset = 1'b0;
    repeat (2) @(negedge clock);

    // Basic ramp 0..179 then constants
    run(180, 32'h0, 32'h1, {32'hCCCC_0003, 32'hBBBB_0002, 32'hAAAA_0001}, 0, 50, 1'b0);
    // No ramp, constants only
    run(0, 32'h1234, 32'h5, {32'd3, 32'd2, 32'd1}, 0, 5, 1'b0);
    // Modular wrap of the ramp accumulator
    run(4, 32'hFFFF_FFFE, 32'h1, {32'h33, 32'h22, 32'h11}, 0, 3, 1'b0);
    // Timeout with done held low
    run(2, 32'h10, 32'h10, {32'h3, 32'h2, 32'h1}, 10, -1, 1'b0);
    // Next start clears the sticky error
    run(1, 32'h7, 32'h0, {32'h6, 32'h5, 32'h4}, 0, 4, 1'b0);
    // done in the same cycle the timeout expires: done wins
    run(3, 32'h100, 32'hFFFF_FFFF, {32'h9, 32'h8, 32'h7}, 10, 12, 1'b0);
    // start pulsed mid-RAMP is dropped
    run(20, 32'hDEAD_0000, 32'h0000_0101, {32'hF3, 32'hF2, 32'hF1}, 0, 6, 1'b1);

    // Randomised runs
    for (int i = 0; i < 6; i++) begin
      len = $urandom_range(0, 30);
      tmo = ($urandom_range(0, 1) == 1) ? 0 : $urandom_range(5, 30);
      d   = $urandom_range(2, 20);
      if (tmo != 0 && d > tmo + 2) d = tmo + 2;
      run(len, $urandom, $urandom, {$urandom, $urandom, $urandom}, tmo, d, 1'b0);
    end

    // Reset mid-CONST: outputs clear immediately, no trigger follows
    len = 6;
    issue_start(len, 32'h40, 32'h4, {32'hC3, 32'hC2, 32'hC1}, 0, e0);
    expect_writes(e0, len, 32'h40, 32'h4, {32'hC3, 32'hC2, 32'hC1});
    while (cyc < e0 + S + len + 2) @(negedge clock);
    chk("mid_const_write", 64'(write), 64'(1));
    #2 reset = 1'b1;
    #1 check_all_zero("async_reset");
    exp_wr_q.delete();
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (60) @(negedge clock);
    check_all_zero("after_abandon");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete at cycle %0d", cyc);
    $fatal(1);
  end

endmodule
